fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
//
// PURPOSE
//   Program-counter register and instruction-fetch sequencer for the MIPS core.
//   PC drives the ADDER A port (B tied to 32'd4 at top level).
//   ADDER O returns as PC_PLUS4 and becomes the next sequential PC.
//   Fetches one word per instruction from instruction memory over a REQ/ACK
//   handshake. Hands {INSTR, INSTR_PC} to decode over a VALID/READY handshake.
//   Accepts branch/jump redirects from the execute stage.
//
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset; bits [1:0] must be 0
//
// PORTS
//   CLK          in   1    rising-edge clock
//   RESET_N      in   1    asynchronous active-low reset
//   PC           out  32   current fetch PC; wired to ADDER.A
//   PC_PLUS4     in   32   ADDER.O (PC+4), combinational from PC
//   IMEM_REQ     out  1    fetch request to instruction memory
//   IMEM_ADDR    out  32   fetch address; always equals PC
//   IMEM_ACK     in   1    memory returns IMEM_DATA this cycle
//   IMEM_DATA    in   32   instruction word, valid when IMEM_ACK=1
//   INSTR        out  32   registered instruction to decode
//   INSTR_PC     out  32   PC of INSTR (used for branch/link math downstream)
//   INSTR_VALID  out  1    INSTR/INSTR_PC valid
//   INSTR_READY  in   1    decode accepts INSTR this cycle
//   REDIRECT     in   1    load REDIRECT_PC (taken branch / jump)
//   REDIRECT_PC  in   32   redirect target
//   MISALIGN     out  1    sticky: a redirect target had [1:0]!=0
//
// BEHAVIOUR
//   Reset (async, RESET_N=0):
//     PC=RESET_PC, state=START.
//     INSTR=0, INSTR_PC=0, INSTR_VALID=0, IMEM_REQ=0, MISALIGN=0.
//   States: START, REQ, HOLD. All updates occur on the CLK rising edge.
//   START
//     IMEM_REQ=0; goes to REQ on the first edge after reset release.
//   REQ
//     IMEM_REQ=1, IMEM_ADDR=PC.
//     On IMEM_ACK: INSTR<=IMEM_DATA, INSTR_PC<=PC, INSTR_VALID<=1,
//     PC<=PC_PLUS4, go to HOLD. Otherwise stay in REQ.
//   HOLD
//     IMEM_REQ=0, INSTR_VALID=1.
//     On INSTR_READY: INSTR_VALID<=0, go to REQ. Otherwise hold all
//     outputs stable.
//   Timing
//     Fetch latency: ACK in cycle N -> INSTR_VALID=1 in cycle N+1.
//     Zero-wait memory gives peak throughput of 1 instruction per 2 cycles.
//   REDIRECT (highest priority, any state except START)
//     PC<={REDIRECT_PC[31:2],2'b00}, INSTR_VALID<=0, go to REQ.
//     A simultaneous IMEM_ACK is discarded: INSTR and INSTR_PC do not update.
//     A simultaneous INSTR_READY is irrelevant; the held word is flushed.
//     If REDIRECT_PC[1:0]!=0, MISALIGN<=1 and stays set until reset.
//     REDIRECT in START is ignored.
//   IMEM_ADDR may change while IMEM_REQ=1 (only after a redirect).
//     Memory samples the address in the ACK cycle only.
//   Wrap-around: PC=32'hFFFF_FFFC advances to 32'h0000_0000 (the ADDER
//     carry is dropped). No flag is raised.
//   Reset asserted mid-fetch or mid-hold: takes effect immediately; the
//     pending word is lost.
//
// TESTING
//   1. Reset, memory always ACKs, READY=1 -> PCs 0,4,8,C.
//      INSTR_VALID toggles 1/0; INSTR_PC matches each word.
//   2. ACK delayed 3 cycles -> IMEM_REQ held 4 cycles, PC stable at 0.
//      INSTR_VALID rises the cycle after ACK.
//   3. READY=0 for 5 cycles while valid -> INSTR, INSTR_PC and VALID stable.
//      No IMEM_REQ; PC already advanced to 4.
//   4. REDIRECT to 32'h0000_0040 in the same cycle as ACK -> word discarded.
//      Next IMEM_ADDR=0x40; next INSTR_PC=0x40.
//   5. REDIRECT to 32'h0000_0042 -> IMEM_ADDR=0x40; MISALIGN=1 until RESET_N=0.
//   6. REDIRECT to 32'hFFFF_FFFC, then fetch -> INSTR_PC=FFFF_FFFC.
//      Next IMEM_ADDR=0x0000_0000.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Fetches one word per instruction over req/ack and hands it to decode over valid/ready.
module fetch_pc_unit #(
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign
);

  typedef enum logic [1:0] {
    StStart,
    StReq,
    StHold
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        instr_valid_q;
  logic        imem_req_q;
  logic        misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StStart;
      pc_q          <= ResetPc;
      instr_q       <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else if (redirect && (state_q != StStart)) begin
      // Redirect wins over ack and ready: any returning or held word is dropped.
      state_q       <= StReq;
      pc_q          <= {redirect_pc[31:2], 2'b00};
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StStart: begin
          state_q    <= StReq;
          imem_req_q <= 1'b1;
        end
        StReq: begin
          if (imem_ack) begin
            state_q       <= StHold;
            instr_q       <= imem_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            pc_q          <= pc_plus4;
          end
        end
        StHold: begin
          if (instr_ready) begin
            state_q       <= StReq;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
          end
        end
        default: begin
          state_q       <= StStart;
          instr_valid_q <= 1'b0;
          imem_req_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: a program-order model pushes expected words into a
// scoreboard, and a separate monitor pops and compares each word decode accepts.
module tb_fetch_pc_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ResetPc(ResetPc)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .misalign    (misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // External adder (carry dropped) and an instruction memory whose contents hash the address.
  assign pc_plus4  = pc + 32'd4;
  assign imem_data = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } fetch_t;

  fetch_t      sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned n_consumed = 0;

  logic [31:0] exp_pc = ResetPc;
  logic        exp_misalign = 1'b0;
  logic        exp_holding = 1'b0;
  logic        started = 1'b0;
  fetch_t      held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check("reset_pc", pc, ResetPc);
    check("reset_instr", instr, 32'h0);
    check("reset_instr_pc", instr_pc, 32'h0);
    check("reset_valid", 32'(instr_valid), 32'h0);
    check("reset_req", 32'(imem_req), 32'h0);
    check("reset_misalign", 32'(misalign), 32'h0);
  endtask

  // Reference model: sequential PC stream, one word in flight, redirects flush and realign.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_pc       = ResetPc;
      exp_misalign = 1'b0;
      exp_holding  = 1'b0;
      started      = 1'b0;
    end else begin
      check("pc", pc, exp_pc);
      check("imem_addr", imem_addr, exp_pc);
      check("imem_req", 32'(imem_req), 32'(started && !exp_holding));
      check("instr_valid", 32'(instr_valid), 32'(exp_holding));
      check("misalign", 32'(misalign), 32'(exp_misalign));
      if (exp_holding) begin
        check("held_instr", instr, held.word);
        check("held_instr_pc", instr_pc, held.addr);
      end
      if (redirect && started) begin
        sb_q.delete();
        exp_holding = 1'b0;
        exp_pc      = redirect_pc & 32'hFFFF_FFFC;
        if (redirect_pc[1:0] != 2'b00) exp_misalign = 1'b1;
      end else if (exp_holding) begin
        if (instr_ready) exp_holding = 1'b0;
      end else if (started && imem_ack) begin
        held        = '{word: mem_word(exp_pc), addr: exp_pc};
        sb_q.push_back(held);
        exp_holding = 1'b1;
        exp_pc      = exp_pc + 32'd4;
      end
      started = 1'b1;
    end
  end

  // Monitor: every word decode actually accepts must be the next one the model expects.
  always @(negedge clk) begin
    #1;
    if (rst_n && instr_valid && instr_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept: got instr %h pc %h, expected no word at %0t", instr, instr_pc,
                 $time);
      end else begin
        fetch_t e;
        e = sb_q.pop_front();
        check("accept_instr", instr, e.word);
        check("accept_instr_pc", instr_pc, e.addr);
        n_consumed++;
      end
    end
  end

  task automatic random_cycles(input int n, input bit allow_mis);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      imem_ack    = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0: redirect_pc = 32'h0000_0040;
        1: redirect_pc = allow_mis ? 32'h0000_0042 : 32'h0000_0044;
        2: redirect_pc = 32'hFFFF_FFFC;
        3: redirect_pc = 32'hFFFF_FFF4;
        default: redirect_pc = allow_mis ? $urandom : ($urandom & 32'hFFFF_FFFC);
      endcase
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    #1;
    rst_n = 1'b1;

    // Zero-wait memory, decode always ready.
    @(posedge clk);
    #1;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    random_cycles(400, 1'b0);

    // Reset in the middle of traffic, then a misaligned redirect that START must ignore.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk);
    #2;
    rst_n       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0083;
    imem_ack    = 1'b0;

    random_cycles(400, 1'b1);

    @(posedge clk);
    #1;
    redirect    = 1'b0;
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("progress", 32'(n_consumed > 100), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
